// File: rtl/seq_divider.sv
// seq_divider: restoring (shift-subtract) sequential divider, one quotient bit
// per clock, with a start/busy/done handshake.
// Optional feature macro: DIV_SIGNED_EN -- when defined, operands and results
// are two's complement (magnitudes go through the unsigned core, signs are
// restored on the edge that raises done). Undefined: unsigned only.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Partial remainder is always < divisor between iterations, so WIDTH bits
  // suffice in storage; the WIDTH+1-bit P exists only as part_sh.
  logic [WIDTH-1:0] part_q, part_d;
  // Dividend shifts out at the MSB while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // Zero divisor: one bubble cycle so done rises one edge after accept.
  logic             zpend_q, zpend_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   part_sh;
  logic             ge;
  logic [WIDTH-1:0] part_sub;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
`endif

  // One restoring iteration: shift in next dividend bit, trial-subtract divisor.
  always_comb begin
    part_sh  = {part_q, dvd_q[WIDTH-1]};
    ge       = (part_sh >= {1'b0, dvs_q});
    part_sub = part_sh[WIDTH-1:0] - dvs_q;
  end

  // Operand magnitudes on the way in, sign restoration on the way out.
  always_comb begin
`ifdef DIV_SIGNED_EN
    dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;
    quo_fix = qneg_q ? (~dvd_q  + 1'b1) : dvd_q;
    rem_fix = rneg_q ? (~part_q + 1'b1) : part_q;
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
    quo_fix = dvd_q;
    rem_fix = part_q;
`endif
  end

  // Next-state and datapath control; everything holds unless changed below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    zpend_d = zpend_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (zpend_q) begin
          // Deliver the divide-by-zero result; start in this cycle is dropped
          // because the previous request is still being answered.
          state_d = DONE;
          zpend_d = 1'b0;
          quo_d   = '1;
          rem_d   = dvd_q;
          dz_d    = 1'b1;
        end else if (start) begin
          if (divisor == '0) begin
            state_d = IDLE;
            zpend_d = 1'b1;
            dvd_d   = dividend;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            part_d  = '0;
            dvd_d   = dvd_mag;
            dvs_d   = dvs_mag;
`ifdef DIV_SIGNED_EN
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = quo_fix;
          rem_d   = rem_fix;
          dz_d    = 1'b0;
        end else begin
          part_d = ge ? part_sub : part_sh[WIDTH-1:0];
          dvd_d  = {dvd_q[WIDTH-2:0], ge};
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      zpend_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      zpend_q <= zpend_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

`ifdef DIV_SIGNED_EN
  // Result sign flags captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`endif

  // Handshake and result outputs straight from registers.
  always_comb begin
    busy        = (state_q == CALC);
    done        = (state_q == DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dz_q;
  end

endmodule
